// File: rtl/Pipe_Buf_Reg_PKG.sv
// Shared pipeline-buffer types: hazard-controller state and EX forwarding-mux encodings.
package Pipe_Buf_Reg_PKG;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Wide enough for the full 1..7 halt-drain range.
  localparam int DRAIN_CNT_W = 3;

endpackage

// File: rtl/fwd_select.sv
// Forwarding compare for one EX source operand; the MEM result is younger, so it wins over WB.
module fwd_select
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int RF_ADDRESS = 5
) (
  input  logic [RF_ADDRESS-1:0] ex_rs,
  input  logic [RF_ADDRESS-1:0] mem_rd,
  input  logic                  mem_regwrite,
  input  logic [RF_ADDRESS-1:0] wb_rd,
  input  logic                  wb_regwrite,
  output fwd_sel_e              sel
);

  // NOTE: every signal written in always_comb is given a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel = FWD_RF;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard / pipeline control for the 5-stage RV32 core: stalls, flushes, forwarding, halt drain.
// Optional stall-cycle counter is built only when PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int RF_ADDRESS = 5,
  parameter int HALT_DRAIN = 3,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RF_ADDRESS-1:0] id_rs1,
  input  logic [RF_ADDRESS-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  input  logic [RF_ADDRESS-1:0] ex_rd,
  input  logic                  ex_memread,
  input  logic [RF_ADDRESS-1:0] ex_rs1,
  input  logic [RF_ADDRESS-1:0] ex_rs2,
  input  logic [RF_ADDRESS-1:0] mem_rd,
  input  logic                  mem_regwrite,
  input  logic [RF_ADDRESS-1:0] wb_rd,
  input  logic                  wb_regwrite,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  halt_req,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  mem_wb_bubble,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cycles
);

  ctrl_state_e            state;
  logic [DRAIN_CNT_W-1:0] drain_cnt;
  logic                   mem_wait;
  logic                   load_use;
  fwd_sel_e               fwd_a_sel;
  fwd_sel_e               fwd_b_sel;

  assign mem_wait = mem_req && !mem_ready;
  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  fwd_select #(.RF_ADDRESS(RF_ADDRESS)) u_fwd_a (
    .ex_rs(ex_rs1), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(fwd_a_sel)
  );

  fwd_select #(.RF_ADDRESS(RF_ADDRESS)) u_fwd_b (
    .ex_rs(ex_rs2), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(fwd_b_sel)
  );

  assign fwd_a  = fwd_a_sel;
  assign fwd_b  = fwd_b_sel;
  assign halted = (state == HALTED);

  // A memory wait freezes everything up to EX, so a pending branch or load-use is simply re-seen later.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_wait) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
          mem_wb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          {pc_en, if_id_en} = 2'b00;
          id_ex_flush       = 1'b1;
        end else if (halt_req) begin
          {pc_en, if_id_en} = 2'b00;
          if_id_flush       = 1'b1;
        end
      end
      DRAIN: begin
        {pc_en, if_id_en} = 2'b00;
        if (mem_wait) begin
          {id_ex_en, ex_mem_en} = 2'b00;
          mem_wb_bubble         = 1'b1;
        end
      end
      default: begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
        mem_wb_bubble = 1'b1;
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments and an asynchronous reset in the sensitivity list.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (!mem_wait && !ex_branch_taken && !load_use && halt_req) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_CNT_W'(HALT_DRAIN);
          end
        end
        DRAIN: begin
          if (!mem_wait) begin
            drain_cnt <= drain_cnt - DRAIN_CNT_W'(1);
            if (drain_cnt == DRAIN_CNT_W'(1)) state <= HALTED;
          end
        end
        default: state <= HALTED;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (!pc_en && (state != HALTED) && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a rule-level model.
module tb_pipe_hazard_ctrl;

  localparam int RF_ADDRESS = 5;
  localparam int HALT_DRAIN = 3;
  localparam int CNT_W      = 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [RF_ADDRESS-1:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic                  id_uses_rs2, ex_memread, mem_regwrite, wb_regwrite;
  logic                  ex_branch_taken, mem_req, mem_ready, halt_req;
  logic                  pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic                  if_id_flush, id_ex_flush, mem_wb_bubble, halted;
  logic [1:0]            fwd_a, fwd_b;
  logic [CNT_W-1:0]      stall_cycles;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = running, 1 = draining, 2 = halted.
  int          m_mode;
  int          m_left;
  logic [31:0] m_stalls;

  pipe_hazard_ctrl #(
    .RF_ADDRESS(RF_ADDRESS), .HALT_DRAIN(HALT_DRAIN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .halt_req(halt_req),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_bubble(mem_wb_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble, halted}
  function automatic logic [7:0] dut_ctrl();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble, halted};
  endfunction

  function automatic logic [7:0] exp_ctrl();
    bit mw = mem_req && !mem_ready;
    bit lu = ex_memread && ex_rd != 0 && (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
    if (m_mode == 2) return 8'b0000_0011;
    if (m_mode == 1) return mw ? 8'b0000_0010 : 8'b0011_0000;
    if (mw)              return 8'b0000_0010;
    if (ex_branch_taken) return 8'b1111_1100;
    if (lu)              return 8'b0011_0100;
    if (halt_req)        return 8'b0011_1000;
    return 8'b1111_0000;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [RF_ADDRESS-1:0] rs);
    if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_regwrite && wb_rd != 0 && wb_rd == rs)    return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] exp_stall();
`ifdef PERF_CNT_EN
    return CNT_W'(m_stalls);
`else
    return '0;
`endif
  endfunction

  // Advance the model by the cycle whose inputs are currently applied, then clock the DUT.
  task automatic tick();
    logic [7:0] c = exp_ctrl();
    bit mw = mem_req && !mem_ready;
    if (m_mode != 2 && !c[7] && m_stalls != 32'hFFFF_FFFF) m_stalls++;
    if (m_mode == 0 && c == 8'b0011_1000) begin
      m_mode = 1;
      m_left = HALT_DRAIN;
    end else if (m_mode == 1 && !mw) begin
      m_left--;
      if (m_left == 0) m_mode = 2;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    {id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd} = '0;
    {id_uses_rs2, ex_memread, mem_regwrite, wb_regwrite} = '0;
    {ex_branch_taken, mem_req, halt_req} = '0;
    mem_ready = 1'b1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    m_mode = 0;
    m_left = 0;
    m_stalls = 0;
    #2;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    m_mode = 0;
    m_stalls = 0;
    #3;
    checks++;
    if (dut_ctrl() !== 8'b1111_0000 || fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall_cycles !== '0) begin
      errors++;
      $display("FAIL reset: ctrl=%b fwd=%b/%b stall=%0d, want ctrl=11110000 fwd=00/00 stall=0",
               dut_ctrl(), fwd_a, fwd_b, stall_cycles);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_forwarding();
    idle_inputs();
    mem_rd = 3; wb_rd = 3; mem_regwrite = 1; wb_regwrite = 1; ex_rs1 = 3; ex_rs2 = 0;
    #1;
    checks++;
    if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
      errors++;
      $display("FAIL fwd_mem_priority: fwd_a=%b fwd_b=%b, want 10/00", fwd_a, fwd_b);
    end
    mem_rd = 0; wb_rd = 0;
    #1;
    checks++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      errors++;
      $display("FAIL fwd_x0: fwd_a=%b fwd_b=%b, want 00/00", fwd_a, fwd_b);
    end
    mem_rd = 7; wb_rd = 3;
    #1;
    checks++;
    if (fwd_a !== 2'b01) begin
      errors++;
      $display("FAIL fwd_wb: fwd_a=%b, want 01", fwd_a);
    end
    for (int i = 0; i < 24; i++) begin
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
      mem_regwrite = 1'($urandom); wb_regwrite = 1'($urandom);
      #1;
      checks++;
      if (fwd_a !== exp_fwd(ex_rs1) || fwd_b !== exp_fwd(ex_rs2)) begin
        errors++;
        $display("FAIL fwd_rand: fwd_a=%b fwd_b=%b, want %b/%b",
                 fwd_a, fwd_b, exp_fwd(ex_rs1), exp_fwd(ex_rs2));
      end
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_load_use();
    idle_inputs();
    ex_memread = 1; ex_rd = 5; id_rs1 = 5;
    #1;
    checks++;
    if (dut_ctrl() !== 8'b0011_0100) begin
      errors++;
      $display("FAIL load_use_stall: ctrl=%b, want 00110100", dut_ctrl());
    end
    tick();
    idle_inputs();
    id_rs1 = 5;
    #1;
    checks++;
    if (dut_ctrl() !== 8'b1111_0000) begin
      errors++;
      $display("FAIL load_use_release: ctrl=%b, want 11110000", dut_ctrl());
    end
    ex_memread = 1; ex_rd = 0; id_rs1 = 0;
    #1;
    checks++;
    if (dut_ctrl() !== 8'b1111_0000) begin
      errors++;
      $display("FAIL load_use_x0: ctrl=%b, want 11110000", dut_ctrl());
    end
    ex_rd = 9; id_rs1 = 1; id_rs2 = 9; id_uses_rs2 = 0;
    #1;
    checks++;
    if (dut_ctrl() !== 8'b1111_0000) begin
      errors++;
      $display("FAIL load_use_rs2_unused: ctrl=%b, want 11110000", dut_ctrl());
    end
    id_uses_rs2 = 1;
    #1;
    checks++;
    if (dut_ctrl() !== 8'b0011_0100) begin
      errors++;
      $display("FAIL load_use_rs2: ctrl=%b, want 00110100", dut_ctrl());
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    idle_inputs();
    mem_req = 1; mem_ready = 0; ex_branch_taken = 1; halt_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (dut_ctrl() !== 8'b0000_0010) begin
        errors++;
        $display("FAIL mem_wait_freeze[%0d]: ctrl=%b, want 00000010", i, dut_ctrl());
      end
      tick();
    end
    mem_ready = 1;
    #1;
    checks++;
    if (dut_ctrl() !== 8'b1111_1100) begin
      errors++;
      $display("FAIL mem_wait_then_branch: ctrl=%b, want 11111100", dut_ctrl());
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (dut_ctrl() !== 8'b1111_0000) begin
      errors++;
      $display("FAIL halt_branch_no_drain: ctrl=%b, want 11110000", dut_ctrl());
    end
  endtask

  task automatic test_halt();
    apply_reset();
    idle_inputs();
    halt_req = 1;
    #1;
    checks++;
    if (dut_ctrl() !== 8'b0011_1000) begin
      errors++;
      $display("FAIL halt_entry: ctrl=%b, want 00111000", dut_ctrl());
    end
    tick();
    halt_req = 0;
    #1;
    checks++;
    if (dut_ctrl() !== 8'b0011_0000) begin
      errors++;
      $display("FAIL drain_1: ctrl=%b, want 00110000", dut_ctrl());
    end
    tick();
    mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
    #1;
    checks++;
    if (dut_ctrl() !== 8'b0000_0010) begin
      errors++;
      $display("FAIL drain_mem_wait: ctrl=%b, want 00000010", dut_ctrl());
    end
    tick();
    mem_ready = 1;
    for (int i = 2; i <= 3; i++) begin
      #1;
      checks++;
      if (dut_ctrl() !== 8'b0011_0000) begin
        errors++;
        $display("FAIL drain_%0d: ctrl=%b, want 00110000", i, dut_ctrl());
      end
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      ex_branch_taken = 1'($urandom); halt_req = 1'($urandom); ex_memread = 1'($urandom);
      #1;
      checks++;
      if (dut_ctrl() !== 8'b0000_0011 || stall_cycles !== exp_stall()) begin
        errors++;
        $display("FAIL halted[%0d]: ctrl=%b stall=%0d, want 00000011 stall=%0d",
                 i, dut_ctrl(), stall_cycles, exp_stall());
      end
      tick();
    end
    apply_reset();
  endtask

  task automatic test_stall_count();
    apply_reset();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      ex_memread = 1; ex_rd = 4; id_rs2 = 4; id_uses_rs2 = 1;
      tick();
      idle_inputs();
      tick();
    end
    mem_req = 1; mem_ready = 0;
    repeat (3) tick();
    idle_inputs();
    #1;
    checks++;
`ifdef PERF_CNT_EN
    if (stall_cycles !== CNT_W'(5)) begin
      errors++;
      $display("FAIL stall_count: got %0d, want 5", stall_cycles);
    end
`else
    if (stall_cycles !== '0) begin
      errors++;
      $display("FAIL stall_count_off: got %0d, want 0", stall_cycles);
    end
`endif
    halt_req = 1;
    tick();
    halt_req = 0;
    tick();
    #2;
    reset = 1'b1;
    m_mode = 0;
    m_stalls = 0;
    #1;
    checks++;
    if (dut_ctrl() !== 8'b1111_0000 || stall_cycles !== '0) begin
      errors++;
      $display("FAIL reset_mid_drain: ctrl=%b stall=%0d, want 11110000 stall=0", dut_ctrl(), stall_cycles);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));  ex_rs1 = 5'($urandom_range(0, 3));
      ex_rs2 = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd = 5'($urandom_range(0, 3));
      id_uses_rs2 = 1'($urandom); ex_memread = ($urandom_range(0, 2) == 0);
      mem_regwrite = 1'($urandom); wb_regwrite = 1'($urandom);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      mem_req = 1'($urandom); mem_ready = ($urandom_range(0, 2) != 0);
      halt_req = ($urandom_range(0, 15) == 0);
      #1;
      checks++;
      if (dut_ctrl() !== exp_ctrl() || fwd_a !== exp_fwd(ex_rs1) || fwd_b !== exp_fwd(ex_rs2) ||
          stall_cycles !== exp_stall()) begin
        errors++;
        $display("FAIL random[%0d]: ctrl=%b fwd=%b/%b stall=%0d, want ctrl=%b fwd=%b/%b stall=%0d",
                 i, dut_ctrl(), fwd_a, fwd_b, stall_cycles,
                 exp_ctrl(), exp_fwd(ex_rs1), exp_fwd(ex_rs2), exp_stall());
      end
      tick();
      if (m_mode == 2 && $urandom_range(0, 3) == 0) apply_reset();
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    m_mode = 0;
    m_left = 0;
    m_stalls = 0;
    @(negedge clk);
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_wait();
    test_halt();
    test_stall_count();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
